// File: rtl/weighted_flow_sched_if.sv
// Stream bundle between the per-flow packet FIFOs, the weighted scheduler and the C2H stream.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface weighted_flow_sched_if #(
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 512,
    parameter int META_W   = 48,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = 4
);
    logic [NUM_CH-1:0]          s_tvalid;
    logic [NUM_CH*DATA_W-1:0]   s_tdata;
    logic [NUM_CH-1:0]          s_tlast;
    logic [NUM_CH*META_W-1:0]   s_tmeta;
    logic [NUM_CH-1:0]          s_tready;
    logic [NUM_CH-1:0]          ch_enable;
    logic [NUM_CH*WEIGHT_W-1:0] ch_weight;
    logic                       crdt_valid;
    logic                       qid_fifo_full;
    logic                       m_tvalid;
    logic [DATA_W-1:0]          m_tdata;
    logic                       m_tlast;
    logic [META_W-1:0]          m_tmeta;
    logic [ID_W-1:0]            m_tid;
    logic                       m_tready;
    logic [31:0]                pkt_cnt;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, s_tmeta, ch_enable, ch_weight,
               crdt_valid, qid_fifo_full, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tmeta, m_tid, pkt_cnt
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, s_tmeta, ch_enable, ch_weight,
               crdt_valid, qid_fifo_full, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tmeta, m_tid, pkt_cnt
    );
endinterface

// File: rtl/weighted_flow_sched.sv
// Packet-atomic weighted round-robin scheduler: NUM_CH per-flow AXIS packet streams onto one
// C2H stream, with per-packet credit gating, flow index and sideband carried with the data.
module weighted_flow_sched #(
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 512,
    parameter int META_W   = 48,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = 4
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    weighted_flow_sched_if.slave  bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     cur_q;
    logic [WEIGHT_W:0]   burst_q;
    logic                m_tvalid_q;
    logic [DATA_W-1:0]   m_tdata_q;
    logic                m_tlast_q;
    logic [META_W-1:0]   m_tmeta_q;
    logic [ID_W-1:0]     m_tid_q;
    logic [31:0]         pkt_cnt_q;

    logic [ID_W-1:0]     cur_d;
    logic [WEIGHT_W:0]   burst_d;
    logic                grant_found;
    logic [ID_W-1:0]     scan_idx;

    logic [DATA_W-1:0]   data_arr [NUM_CH];
    logic [META_W-1:0]   meta_arr [NUM_CH];
    logic [WEIGHT_W:0]   wgt_arr  [NUM_CH];
    logic [NUM_CH-1:0]   eligible;

    logic gate;
    logic out_rdy;
    logic accept;

    assign gate    = bus.crdt_valid & ~bus.qid_fifo_full;
    assign out_rdy = ~m_tvalid_q | bus.m_tready;
    assign accept  = (state_q == XFER) & bus.s_tvalid[cur_q] & out_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_flow
            assign data_arr[gi] = bus.s_tdata[gi*DATA_W +: DATA_W];
            assign meta_arr[gi] = bus.s_tmeta[gi*META_W +: META_W];
            // A zero weight still earns one packet per turn.
            assign wgt_arr[gi]  = (bus.ch_weight[gi*WEIGHT_W +: WEIGHT_W] == '0) ?
                                  (WEIGHT_W+1)'(1) :
                                  {1'b0, bus.ch_weight[gi*WEIGHT_W +: WEIGHT_W]};
            assign eligible[gi] = bus.s_tvalid[gi] & bus.ch_enable[gi];
            assign bus.s_tready[gi] = (state_q == XFER) && (cur_q == ID_W'(gi)) && out_rdy;
        end
    endgenerate

    // burst_q == 0 only right after reset: no flow holds a turn yet, so the scan starts at flow 0.
    always_comb begin
        cur_d       = cur_q;
        burst_d     = (WEIGHT_W+1)'(1);
        grant_found = 1'b0;
        scan_idx    = '0;
        if (eligible[cur_q] && (burst_q != '0) && (burst_q < wgt_arr[cur_q])) begin
            grant_found = 1'b1;
            burst_d     = burst_q + 1'b1;
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                scan_idx = ID_W'((int'(cur_q) + k) % NUM_CH);
                if (!grant_found && eligible[scan_idx]) begin
                    grant_found = 1'b1;
                    cur_d       = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q    <= IDLE;
            cur_q      <= ID_W'(NUM_CH - 1);
            burst_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tmeta_q  <= '0;
            m_tid_q    <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (accept) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= data_arr[cur_q];
                m_tlast_q  <= bus.s_tlast[cur_q];
            end else if (bus.m_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (gate && grant_found) begin
                        state_q   <= XFER;
                        cur_q     <= cur_d;
                        burst_q   <= burst_d;
                        m_tid_q   <= cur_d;
                        m_tmeta_q <= meta_arr[cur_d];
                    end
                end
                XFER: begin
                    // Gate and enables are deliberately ignored until the packet's last beat.
                    if (accept && bus.s_tlast[cur_q]) begin
                        state_q   <= IDLE;
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tmeta  = m_tmeta_q;
    assign bus.m_tid    = m_tid_q;
    assign bus.pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_weighted_flow_sched.sv
// Directed bench for weighted_flow_sched: per-flow packet sources, an output beat log and
// hand-derived expected grant orders and beat contents.
module tb_weighted_flow_sched;
    localparam int NCH = 16;
    localparam int DW  = 32;
    localparam int MW  = 48;
    localparam int WW  = 4;
    localparam int IW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weighted_flow_sched_if #(.NUM_CH(NCH), .DATA_W(DW), .META_W(MW), .WEIGHT_W(WW), .ID_W(IW)) bus ();

    weighted_flow_sched #(.NUM_CH(NCH), .DATA_W(DW), .META_W(MW), .WEIGHT_W(WW), .ID_W(IW)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .bus        (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [NCH-1:0] src_en;
    int             src_len  [NCH];
    int             src_beat [NCH];
    int             src_pkt  [NCH];

    logic [DW-1:0]  out_data [$];
    logic           out_last [$];
    logic [IW-1:0]  out_tid  [$];
    int             out_pkts;
    int             acc_lasts;
    logic           prev_last;

    function automatic logic [DW-1:0] beat_word(int f, int p, int b);
        return {8'(f), 8'(p), 16'(b)};
    endfunction

    function automatic logic [MW-1:0] meta_word(int f, int p, int len);
        return {16'(len * 64), 8'(f), 8'(p), 16'h00A5};
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NCH; i++) begin
            bus.s_tvalid[i]          = src_en[i];
            bus.s_tdata[i*DW +: DW]  = beat_word(i, src_pkt[i], src_beat[i]);
            bus.s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
            bus.s_tmeta[i*MW +: MW]  = meta_word(i, src_pkt[i], src_len[i]);
        end
    endtask

    task automatic set_weights_one();
        for (int i = 0; i < NCH; i++) bus.ch_weight[i*WW +: WW] = 4'd1;
    endtask

    task automatic clear_log();
        out_data.delete();
        out_last.delete();
        out_tid.delete();
        out_pkts  = 0;
        acc_lasts = 0;
        prev_last = 1'b0;
    endtask

    // One clock: sample handshakes on the falling edge, update sources after the rising edge.
    task automatic tick();
        logic [NCH-1:0] hs;
        logic           ohs, rst_pre, acc_last, ol;
        logic [DW-1:0]  acc_data, od;
        logic [IW-1:0]  ot;
        @(negedge clk);
        rst_pre = rst;
        if (prev_last && !rst_pre) begin
            vectors++;
            if (bus.s_tready !== '0) begin
                miscompares++;
                $display("FAIL gap: s_tready=%h after tlast, expected 0", bus.s_tready);
            end
        end
        hs  = bus.s_tvalid & bus.s_tready;
        ohs = bus.m_tvalid & bus.m_tready;
        od  = bus.m_tdata;
        ol  = bus.m_tlast;
        ot  = bus.m_tid;
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (hs[i]) begin
                acc_data = bus.s_tdata[i*DW +: DW];
                acc_last = bus.s_tlast[i];
            end
        end
        @(posedge clk);
        #1;
        if (ohs) begin
            out_data.push_back(od);
            out_last.push_back(ol);
            out_tid.push_back(ot);
            if (ol) out_pkts++;
        end
        prev_last = 1'b0;
        if (rst_pre) begin
            acc_lasts = 0;
        end else if (hs != '0) begin
            vectors++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== acc_data || bus.m_tlast !== acc_last) begin
                miscompares++;
                $display("FAIL latency: m_tvalid=%b m_tdata=%h m_tlast=%b, expected 1 %h %b",
                         bus.m_tvalid, bus.m_tdata, bus.m_tlast, acc_data, acc_last);
            end
            for (int i = 0; i < NCH; i++) begin
                if (hs[i]) begin
                    if (src_beat[i] == src_len[i] - 1) begin
                        src_beat[i] = 0;
                        src_pkt[i]++;
                    end else begin
                        src_beat[i]++;
                    end
                end
            end
            if (acc_last) begin
                acc_lasts++;
                prev_last = 1'b1;
            end
        end
        drive_src();
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            src_beat[i] = 0;
            src_pkt[i]  = 0;
        end
        drive_src();
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        src_en = '0;
        bus.ch_enable = '0;
        hard_reset();
        vectors++;
        if (bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b expected 0", bus.m_tvalid); end
        vectors++;
        if (bus.m_tdata !== '0) begin miscompares++; $display("FAIL reset_m_tdata: got %h expected 0", bus.m_tdata); end
        vectors++;
        if (bus.m_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_m_tlast: got %b expected 0", bus.m_tlast); end
        vectors++;
        if (bus.m_tmeta !== '0) begin miscompares++; $display("FAIL reset_m_tmeta: got %h expected 0", bus.m_tmeta); end
        vectors++;
        if (bus.m_tid !== '0) begin miscompares++; $display("FAIL reset_m_tid: got %0d expected 0", bus.m_tid); end
        vectors++;
        if (bus.s_tready !== '0) begin miscompares++; $display("FAIL reset_s_tready: got %h expected 0", bus.s_tready); end
        vectors++;
        if (bus.pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_cnt: got %0d expected 0", bus.pkt_cnt); end
    endtask

    task automatic test_weights();
        int exp_tid [8] = '{0, 3, 3, 3, 0, 3, 3, 3};
        int n [NCH];
        int cyc, f, b;
        logic [DW-1:0] ed;
        set_weights_one();
        bus.ch_weight[0*WW +: WW] = 4'd0;
        bus.ch_weight[3*WW +: WW] = 4'd3;
        src_en = 16'h0009;
        bus.ch_enable = 16'h0009;
        for (int i = 0; i < NCH; i++) begin src_len[i] = 2; n[i] = 0; end
        bus.crdt_valid = 1'b1; bus.qid_fifo_full = 1'b0; bus.m_tready = 1'b1;
        hard_reset();
        cyc = 0;
        while (out_pkts < 8 && cyc < 200) begin tick(); cyc++; end
        vectors++;
        if (out_pkts < 8) begin miscompares++; $display("FAIL weights_timeout: got %0d packets expected 8", out_pkts); end
        for (int j = 0; j < out_data.size() && j < 16; j++) begin
            f  = exp_tid[j/2];
            b  = j % 2;
            ed = beat_word(f, n[f], b);
            vectors++;
            if (out_data[j] !== ed || out_tid[j] !== IW'(f) || out_last[j] !== (b == 1)) begin
                miscompares++;
                $display("FAIL weights_beat%0d: got data=%h tid=%0d last=%b expected data=%h tid=%0d last=%b",
                         j, out_data[j], out_tid[j], out_last[j], ed, f, (b == 1));
            end
            if (b == 1) n[f]++;
        end
        vectors++;
        if (bus.pkt_cnt !== 32'(acc_lasts)) begin miscompares++; $display("FAIL weights_pkt_cnt: got %0d expected %0d", bus.pkt_cnt, acc_lasts); end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [DW-1:0] ed;
        set_weights_one();
        bus.ch_weight[5*WW +: WW] = 4'd2;
        src_en = 16'h0020;
        bus.ch_enable = 16'h0020;
        for (int i = 0; i < NCH; i++) src_len[i] = 4;
        hard_reset();
        cyc = 0;
        while (out_data.size() < 12 && cyc < 300) begin
            bus.m_tready = (cyc % 2 == 0);
            tick();
            cyc++;
        end
        bus.m_tready = 1'b1;
        vectors++;
        if (out_data.size() != 12) begin miscompares++; $display("FAIL bp_count: got %0d beats expected 12", out_data.size()); end
        for (int j = 0; j < out_data.size() && j < 12; j++) begin
            ed = beat_word(5, j / 4, j % 4);
            vectors++;
            if (out_data[j] !== ed || out_tid[j] !== IW'(5) || out_last[j] !== (j % 4 == 3)) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got data=%h tid=%0d last=%b expected data=%h tid=5 last=%b",
                         j, out_data[j], out_tid[j], out_last[j], ed, (j % 4 == 3));
            end
        end
        vectors++;
        if (bus.pkt_cnt !== 32'd3) begin miscompares++; $display("FAIL bp_pkt_cnt: got %0d expected 3", bus.pkt_cnt); end
    endtask

    task automatic test_credit();
        int cyc;
        logic [DW-1:0] ed;
        set_weights_one();
        src_en = 16'h0002;
        bus.ch_enable = 16'h0002;
        for (int i = 0; i < NCH; i++) src_len[i] = 8;
        bus.crdt_valid = 1'b1;
        hard_reset();
        cyc = 0;
        while (src_beat[1] != 2 && cyc < 50) begin tick(); cyc++; end
        bus.crdt_valid = 1'b0;
        cyc = 0;
        while (out_data.size() < 8 && cyc < 100) begin tick(); cyc++; end
        vectors++;
        if (out_data.size() != 8) begin miscompares++; $display("FAIL credit_count: got %0d beats expected 8", out_data.size()); end
        for (int j = 0; j < out_data.size() && j < 8; j++) begin
            ed = beat_word(1, 0, j);
            vectors++;
            if (out_data[j] !== ed || out_last[j] !== (j == 7)) begin
                miscompares++;
                $display("FAIL credit_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         j, out_data[j], out_last[j], ed, (j == 7));
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (bus.s_tready !== '0 || bus.m_tvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL credit_hold%0d: s_tready=%h m_tvalid=%b expected 0 0", k, bus.s_tready, bus.m_tvalid);
            end
        end
        vectors++;
        if (bus.m_tmeta !== meta_word(1, 0, 8) || bus.m_tid !== IW'(1)) begin
            miscompares++;
            $display("FAIL credit_meta: got meta=%h tid=%0d expected meta=%h tid=1", bus.m_tmeta, bus.m_tid, meta_word(1, 0, 8));
        end
        bus.crdt_valid = 1'b1;
        cyc = 0;
        while (out_data.size() < 9 && cyc < 30) begin tick(); cyc++; end
        vectors++;
        if (out_data.size() < 9) begin
            miscompares++;
            $display("FAIL credit_resume: got %0d beats expected 9", out_data.size());
        end else if (out_data[8] !== beat_word(1, 1, 0) || out_tid[8] !== IW'(1)) begin
            miscompares++;
            $display("FAIL credit_resume: got data=%h tid=%0d expected data=%h tid=1", out_data[8], out_tid[8], beat_word(1, 1, 0));
        end
        vectors++;
        if (bus.pkt_cnt !== 32'(acc_lasts)) begin miscompares++; $display("FAIL credit_pkt_cnt: got %0d expected %0d", bus.pkt_cnt, acc_lasts); end
    endtask

    task automatic test_disable();
        int cyc;
        logic [DW-1:0] ed;
        logic [IW-1:0] et;
        set_weights_one();
        src_en = 16'h0014;
        bus.ch_enable = 16'h0014;
        for (int i = 0; i < NCH; i++) src_len[i] = 3;
        hard_reset();
        cyc = 0;
        while (src_beat[2] != 1 && cyc < 50) begin tick(); cyc++; end
        bus.ch_enable[2] = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        vectors++;
        if (out_data.size() < 6) begin miscompares++; $display("FAIL disable_count: got %0d beats expected at least 6", out_data.size()); end
        for (int j = 0; j < out_data.size(); j++) begin
            if (j < 3) begin
                ed = beat_word(2, 0, j);
                et = IW'(2);
            end else begin
                ed = beat_word(4, (j - 3) / 3, (j - 3) % 3);
                et = IW'(4);
            end
            vectors++;
            if (out_data[j] !== ed || out_tid[j] !== et || out_last[j] !== ((j % 3) == 2)) begin
                miscompares++;
                $display("FAIL disable_beat%0d: got data=%h tid=%0d last=%b expected data=%h tid=%0d last=%b",
                         j, out_data[j], out_tid[j], out_last[j], ed, et, ((j % 3) == 2));
            end
        end
        vectors++;
        if (src_pkt[2] != 1 || src_beat[2] != 0) begin
            miscompares++;
            $display("FAIL disable_flow2: got pkt=%0d beat=%0d expected pkt=1 beat=0", src_pkt[2], src_beat[2]);
        end
    endtask

    task automatic test_qid();
        int cyc;
        logic [DW-1:0] ed;
        set_weights_one();
        src_en = '1;
        bus.ch_enable = '1;
        for (int i = 0; i < NCH; i++) src_len[i] = 1;
        bus.qid_fifo_full = 1'b1;
        hard_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (bus.s_tready !== '0 || bus.m_tvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL qid_hold%0d: s_tready=%h m_tvalid=%b expected 0 0", k, bus.s_tready, bus.m_tvalid);
            end
        end
        bus.qid_fifo_full = 1'b0;
        cyc = 0;
        while (out_data.size() < 20 && cyc < 200) begin tick(); cyc++; end
        vectors++;
        if (out_data.size() != 20) begin miscompares++; $display("FAIL qid_count: got %0d beats expected 20", out_data.size()); end
        for (int j = 0; j < out_data.size() && j < 20; j++) begin
            ed = beat_word(j % 16, j / 16, 0);
            vectors++;
            if (out_tid[j] !== IW'(j % 16) || out_data[j] !== ed || out_last[j] !== 1'b1) begin
                miscompares++;
                $display("FAIL qid_order%0d: got tid=%0d data=%h last=%b expected tid=%0d data=%h last=1",
                         j, out_tid[j], out_data[j], out_last[j], j % 16, ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_weights_one();
        src_en = 16'h0040;
        bus.ch_enable = 16'h0040;
        for (int i = 0; i < NCH; i++) src_len[i] = 6;
        hard_reset();
        cyc = 0;
        while (!(src_pkt[6] == 1 && src_beat[6] == 3) && cyc < 100) begin tick(); cyc++; end
        vectors++;
        if (bus.pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL rstmid_pre_cnt: got %0d expected 1", bus.pkt_cnt); end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_m_tvalid: got %b expected 0", bus.m_tvalid); end
        vectors++;
        if (bus.pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL rstmid_pkt_cnt: got %0d expected 0", bus.pkt_cnt); end
        vectors++;
        if (bus.s_tready !== '0) begin miscompares++; $display("FAIL rstmid_s_tready: got %h expected 0", bus.s_tready); end
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) begin src_beat[i] = 0; src_pkt[i] = 0; end
        src_en = 16'h0041;
        bus.ch_enable = 16'h0041;
        drive_src();
        clear_log();
        cyc = 0;
        while (out_pkts < 2 && cyc < 100) begin tick(); cyc++; end
        vectors++;
        if (out_data.size() < 12) begin
            miscompares++;
            $display("FAIL rstmid_restart: got %0d beats expected 12", out_data.size());
        end else begin
            if (out_tid[0] !== IW'(0) || out_data[0] !== beat_word(0, 0, 0) ||
                out_tid[6] !== IW'(6) || out_data[6] !== beat_word(6, 0, 0)) begin
                miscompares++;
                $display("FAIL rstmid_restart: got tid=%0d,%0d data=%h,%h expected tid=0,6 data=%h,%h",
                         out_tid[0], out_tid[6], out_data[0], out_data[6], beat_word(0, 0, 0), beat_word(6, 0, 0));
            end
        end
        vectors++;
        if (bus.pkt_cnt !== 32'(acc_lasts)) begin miscompares++; $display("FAIL rstmid_pkt_cnt2: got %0d expected %0d", bus.pkt_cnt, acc_lasts); end
    endtask

    initial begin
        src_en = '0;
        for (int i = 0; i < NCH; i++) begin src_len[i] = 1; src_beat[i] = 0; src_pkt[i] = 0; end
        bus.ch_enable     = '0;
        bus.crdt_valid    = 1'b1;
        bus.qid_fifo_full = 1'b0;
        bus.m_tready      = 1'b1;
        set_weights_one();
        drive_src();
        clear_log();
        test_reset();
        test_weights();
        test_backpressure();
        test_credit();
        test_disable();
        test_qid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
